temp_frontend: RTL and testbench

- Upstream stage of the dT estimator. Accepts raw unsigned ADC temperature samples over a valid/ready handshake.
- Block-averages 2^AVG_LOG2 samples, removes the offset, scales by a shift, and saturates to Q7.0.
- Holds the result stable on T_out for the estimator's T_cur input.
- Generates the estimator's 1-cycle init pulse after startup, re-enable or sample dropout, so the estimator never sees a spurious step.

---
 rtl/temp_pkg.sv | 16 +
 rtl/temp_scale_sat.sv | 34 +++
 rtl/temp_frontend.sv | 161 ++++++++++++++++
 tb/tb_temp_frontend.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// Shared types and Q-format constants for the temperature sensor front ends.
package temp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        STALE = 2'd3
    } fe_state_t;

    localparam int Q7_W    = 8;
    localparam int Q7_MAX  = 127;
    localparam int Q7_MIN  = -128;
    localparam int SHIFT_W = 4;

endpackage

// File: rtl/temp_scale_sat.sv
// Combinational offset removal, arithmetic right shift and Q7.0 saturation.
module temp_scale_sat
    import temp_pkg::*;
#(
    parameter int W_IN = 12
) (
    input  logic        [W_IN-1:0]    avg,
    input  logic        [W_IN-1:0]    offset,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [Q7_W-1:0]    q_out,
    output logic                      sat
);

    localparam logic signed [W_IN:0] HI = (W_IN+1)'(Q7_MAX);
    localparam logic signed [W_IN:0] LO = (W_IN+1)'(Q7_MIN);

    logic signed [W_IN:0] diff;
    logic signed [W_IN:0] scaled;

    always_comb begin
        diff   = $signed({1'b0, avg}) - $signed({1'b0, offset});
        scaled = diff >>> shift;
        q_out  = scaled[Q7_W-1:0];
        sat    = 1'b0;
        if (scaled > HI) begin
            q_out = Q7_W'(Q7_MAX);
            sat   = 1'b1;
        end else if (scaled < LO) begin
            q_out = Q7_W'(Q7_MIN);
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/temp_frontend.sv
// ADC temperature front end: block average, offset/scale/saturate, and estimator init pulse.
//   state | meaning
//   IDLE  | block disabled, not accepting samples
//   FILL  | first window after enable
//   RUN   | steady state, dropout timer armed
//   STALE | dropout detected, refilling a window
module temp_frontend
    import temp_pkg::*;
#(
    parameter int W_RAW       = 12,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic        [W_RAW-1:0]  raw_data,
    input  logic                     raw_valid,
    output logic                     raw_ready,
    input  logic        [W_RAW-1:0]  cfg_offset,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    output logic signed [Q7_W-1:0]   T_out,
    output logic                     t_strobe,
    output logic                     t_valid,
    output logic                     init_out,
    output logic                     stale,
    output logic                     sat
);

    localparam int ACC_W = W_RAW + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam bit HOLD_OFF = (AVG_LOG2 == 0);

    fe_state_t               state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic signed [Q7_W-1:0]  t_out_q, t_out_d;
    logic                    t_strobe_q, t_strobe_d;
    logic                    t_valid_q, t_valid_d;
    logic                    init_pend_q, init_pend_d;
    logic                    init_out_q, init_out_d;
    logic                    stale_q, stale_d;
    logic                    sat_q, sat_d;
    logic                    raw_ready_q, raw_ready_d;

    logic [ACC_W-1:0]        sum;
    logic [W_RAW-1:0]        avg;
    logic signed [Q7_W-1:0]  q_res;
    logic                    q_sat;
    logic                    accept;
    logic                    win_done;

    assign sum      = acc_q + ACC_W'(raw_data);
    assign avg      = W_RAW'(sum >> AVG_LOG2);
    assign accept   = raw_valid && raw_ready_q;
    assign win_done = accept && (cnt_q == CNT_LAST);

    temp_scale_sat #(.W_IN(W_RAW)) u_scale (
        .avg    (avg),
        .offset (cfg_offset),
        .shift  (cfg_shift),
        .q_out  (q_res),
        .sat    (q_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        t_out_d     = t_out_q;
        t_strobe_d  = 1'b0;
        t_valid_d   = t_valid_q;
        init_pend_d = 1'b0;
        init_out_d  = init_pend_q && en;
        stale_d     = stale_q;
        sat_d       = 1'b0;

        if (!en) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            tmo_d     = '0;
            t_valid_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = FILL;
        end else if (accept) begin
            tmo_d = TMO_LOAD;
            if (win_done) begin
                state_d     = RUN;
                acc_d       = '0;
                cnt_d       = '0;
                t_out_d     = q_res;
                t_strobe_d  = 1'b1;
                sat_d       = q_sat;
                t_valid_d   = 1'b1;
                stale_d     = 1'b0;
                init_pend_d = (state_q != RUN);
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q == RUN) begin
            if (tmo_q == '0) begin
                state_d   = STALE;
                stale_d   = 1'b1;
                t_valid_d = 1'b0;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end

        // Single-sample windows would strobe on the init cycle; stall one sample instead.
        raw_ready_d = (state_d != IDLE) && !(HOLD_OFF && init_pend_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            t_out_q     <= '0;
            t_strobe_q  <= 1'b0;
            t_valid_q   <= 1'b0;
            init_pend_q <= 1'b0;
            init_out_q  <= 1'b0;
            stale_q     <= 1'b0;
            sat_q       <= 1'b0;
            raw_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            t_out_q     <= t_out_d;
            t_strobe_q  <= t_strobe_d;
            t_valid_q   <= t_valid_d;
            init_pend_q <= init_pend_d;
            init_out_q  <= init_out_d;
            stale_q     <= stale_d;
            sat_q       <= sat_d;
            raw_ready_q <= raw_ready_d;
        end
    end

    assign raw_ready = raw_ready_q;
    assign T_out     = t_out_q;
    assign t_strobe  = t_strobe_q;
    assign t_valid   = t_valid_q;
    assign init_out  = init_out_q;
    assign stale     = stale_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_temp_frontend.sv
// Scoreboard bench for temp_frontend: directed test-plan cases followed by randomized traffic.
module tb_temp_frontend;

    localparam int W_RAW       = 12;
    localparam int AVG_LOG2    = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int WIN         = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_RUN   = 2;
    localparam int M_STALE = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [W_RAW-1:0]  raw_data;
    logic              raw_valid;
    logic              raw_ready;
    logic [W_RAW-1:0]  cfg_offset;
    logic [3:0]        cfg_shift;
    logic signed [7:0] T_out;
    logic              t_strobe;
    logic              t_valid;
    logic              init_out;
    logic              stale;
    logic              sat;

    always #5 clk = ~clk;

    temp_frontend #(
        .W_RAW       (W_RAW),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .raw_data   (raw_data),
        .raw_valid  (raw_valid),
        .raw_ready  (raw_ready),
        .cfg_offset (cfg_offset),
        .cfg_shift  (cfg_shift),
        .T_out      (T_out),
        .t_strobe   (t_strobe),
        .t_valid    (t_valid),
        .init_out   (init_out),
        .stale      (stale),
        .sat        (sat)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, describing the block after the next clock edge.
    int m_mode      = M_IDLE;
    int win[$];
    int idle_cnt    = 0;
    int m_t_out     = 0;
    bit m_t_valid   = 1'b0;
    bit m_stale     = 1'b0;
    bit m_ready     = 1'b0;
    bit m_init_pend = 1'b0;

    typedef struct {
        int val;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   init_q[$];

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic int ref_result(input int sum, input int off, input int sh, output int s);
        int a;
        int d;
        int div;
        int q;
        a   = sum / WIN;
        d   = a - off;
        div = 1 << sh;
        if (d >= 0) q = d / div;
        else        q = -((-d + div - 1) / div);
        s = 0;
        if (q > 127) begin
            s = 1;
            q = 127;
        end else if (q < -128) begin
            s = 1;
            q = -128;
        end
        return q;
    endfunction

    task automatic model_step();
        int   c;
        bit   acc_ok;
        int   sum;
        int   s;
        exp_t e;
        c = cyc;
        if (m_init_pend) begin
            if (en && !rst) init_q.push_back(c + 1);
            m_init_pend = 1'b0;
        end
        if (rst) begin
            m_mode    = M_IDLE;
            win.delete();
            idle_cnt  = 0;
            m_t_out   = 0;
            m_t_valid = 1'b0;
            m_stale   = 1'b0;
        end else if (!en) begin
            m_mode    = M_IDLE;
            win.delete();
            idle_cnt  = 0;
            m_t_valid = 1'b0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_FILL;
        end else begin
            acc_ok = raw_valid && m_ready;
            if (acc_ok) begin
                idle_cnt = 0;
                win.push_back(int'(raw_data));
                if (win.size() == WIN) begin
                    sum = 0;
                    foreach (win[i]) sum += win[i];
                    e.val = ref_result(sum, int'(cfg_offset), int'(cfg_shift), s);
                    e.sat = s;
                    e.cyc = c + 1;
                    sb_q.push_back(e);
                    m_t_out     = e.val;
                    m_t_valid   = 1'b1;
                    m_stale     = 1'b0;
                    m_init_pend = (m_mode != M_RUN);
                    m_mode      = M_RUN;
                    win.delete();
                end
            end else if (m_mode == M_RUN) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT_CYC) begin
                    m_mode    = M_STALE;
                    m_stale   = 1'b1;
                    m_t_valid = 1'b0;
                    idle_cnt  = 0;
                    win.delete();
                end
            end
        end
        m_ready = (m_mode != M_IDLE);
    endtask

    // Drives one cycle's inputs (en/rst/cfg already set by the caller) and advances to the next negedge.
    task automatic tick(input bit v, input int d);
        raw_valid = v;
        raw_data  = W_RAW'(d);
        model_step();
        @(negedge clk);
    endtask

    task automatic window(input int d);
        repeat (WIN) tick(1'b1, d);
    endtask

    initial begin : monitor
        exp_t e;
        int   ic;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                chk("strobe_missing", cyc, e.cyc);
            end
            if (init_q.size() > 0 && init_q[0] < cyc) begin
                ic = init_q.pop_front();
                chk("init_missing", cyc, ic);
            end
            if (t_strobe) begin
                if (sb_q.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("sb_t_out", int'(T_out), e.val);
                    chk("sb_sat", int'(sat), e.sat);
                end
            end else begin
                chk("sat_without_strobe", int'(sat), 0);
            end
            if (init_out) begin
                chk("init_with_strobe", int'(t_strobe), 0);
                if (init_q.size() == 0) begin
                    chk("init_unexpected", 1, 0);
                end else begin
                    ic = init_q.pop_front();
                    chk("init_cycle", cyc, ic);
                end
            end
            chk("hold_t_out", int'(T_out), m_t_out);
            chk("t_valid", int'(t_valid), int'(m_t_valid));
            chk("stale", int'(stale), int'(m_stale));
            chk("raw_ready", int'(raw_ready), int'(m_ready));
        end
    end

    initial begin : driver
        int r;
        rst        = 1'b1;
        en         = 1'b0;
        raw_valid  = 1'b0;
        raw_data   = '0;
        cfg_offset = 12'd2048;
        cfg_shift  = 4'd4;
        @(negedge clk);
        repeat (3) tick(1'b0, 0);
        chk("rst_t_out", int'(T_out), 0);
        chk("rst_t_valid", int'(t_valid), 0);
        chk("rst_raw_ready", int'(raw_ready), 0);
        chk("rst_init", int'(init_out), 0);
        chk("rst_strobe", int'(t_strobe), 0);
        chk("rst_stale", int'(stale), 0);
        rst = 1'b0;

        // Basic window
        en = 1'b1;
        tick(1'b0, 0);
        chk("fill_ready", int'(raw_ready), 1);
        window(2208);
        chk("basic_t_out", int'(T_out), 10);
        chk("basic_strobe", int'(t_strobe), 1);
        chk("basic_sat", int'(sat), 0);
        chk("basic_t_valid", int'(t_valid), 1);
        chk("basic_no_init_yet", int'(init_out), 0);
        tick(1'b0, 0);
        chk("basic_init", int'(init_out), 1);
        chk("basic_strobe_low", int'(t_strobe), 0);
        tick(1'b0, 0);
        chk("basic_init_single", int'(init_out), 0);

        // Steady run
        window(2224);
        chk("steady_11", int'(T_out), 11);
        tick(1'b0, 0);
        tick(1'b0, 0);
        chk("steady_hold", int'(T_out), 11);
        chk("steady_no_init", int'(init_out), 0);
        window(2192);
        chk("steady_9", int'(T_out), 9);
        tick(1'b0, 0);
        chk("steady_no_init2", int'(init_out), 0);

        // Dropout: one idle cycle already spent above
        repeat (62) tick(1'b0, 0);
        chk("drop_63_stale", int'(stale), 0);
        tick(1'b0, 0);
        chk("drop_64_stale", int'(stale), 1);
        chk("drop_64_t_valid", int'(t_valid), 0);
        chk("drop_hold", int'(T_out), 9);
        window(2208);
        chk("recover_t_out", int'(T_out), 10);
        chk("recover_stale", int'(stale), 0);
        chk("recover_t_valid", int'(t_valid), 1);
        tick(1'b0, 0);
        chk("recover_init", int'(init_out), 1);
        repeat (62) tick(1'b0, 0);
        tick(1'b1, 2208);
        tick(1'b0, 0);
        chk("edge_sample_no_stale", int'(stale), 0);
        chk("edge_sample_t_valid", int'(t_valid), 1);
        repeat (3) tick(1'b1, 2208);
        chk("edge_window_t_out", int'(T_out), 10);

        // en drop mid-window
        tick(1'b1, 2000);
        tick(1'b1, 2000);
        en = 1'b0;
        tick(1'b0, 0);
        chk("endrop_t_valid", int'(t_valid), 0);
        chk("endrop_ready", int'(raw_ready), 0);
        chk("endrop_hold", int'(T_out), 10);
        en = 1'b1;
        tick(1'b0, 0);
        window(2048);
        chk("reen_t_out", int'(T_out), 0);
        chk("reen_strobe", int'(t_strobe), 1);
        tick(1'b0, 0);
        chk("reen_init", int'(init_out), 1);

        // Reset between strobe and init
        en = 1'b0;
        tick(1'b0, 0);
        en = 1'b1;
        tick(1'b0, 0);
        window(2208);
        chk("prerst_t_out", int'(T_out), 10);
        rst = 1'b1;
        tick(1'b0, 0);
        chk("midinit_rst_t_out", int'(T_out), 0);
        chk("midinit_rst_init", int'(init_out), 0);
        chk("midinit_rst_t_valid", int'(t_valid), 0);
        rst = 1'b0;
        tick(1'b0, 0);
        chk("midinit_no_init", int'(init_out), 0);
        tick(1'b0, 0);

        // Saturation
        cfg_offset = 12'd2048;
        cfg_shift  = 4'd0;
        window(0);
        chk("neg_sat_t_out", int'(T_out), -128);
        chk("neg_sat_flag", int'(sat), 1);
        tick(1'b0, 0);
        chk("neg_sat_init", int'(init_out), 1);
        cfg_offset = 12'd0;
        window(4095);
        chk("pos_sat_t_out", int'(T_out), 127);
        chk("pos_sat_flag", int'(sat), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) en = ~en;
            if (r >= 5 && r < 10) begin
                cfg_offset = W_RAW'($urandom_range(0, 4095));
                cfg_shift  = 4'($urandom_range(0, 15));
            end
            if (r == 2) begin
                repeat ($urandom_range(60, 70)) tick(1'b0, 0);
            end else if (r == 3) begin
                rst = 1'b1;
                tick(1'b0, 0);
                rst = 1'b0;
            end else begin
                tick(($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)));
            end
        end

        rst = 1'b0;
        en  = 1'b1;
        repeat (5) tick(1'b0, 0);
        chk("sb_drained", sb_q.size(), 0);
        chk("init_drained", init_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
